misaligned_load_store_unit: RTL and testbench

MISALIGNED_LOAD_STORE_UNIT -- requirements
Module: misaligned_load_store_unit

---
 rtl/misaligned_load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_misaligned_load_store_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misaligned_load_store_unit.sv
// Load/store unit: turns one LOAD/STORE request into one or two bus beats.
// Misaligned accesses are split or faulted, and each beat has a timeout.
module misaligned_load_store_unit #(
    parameter int XLEN           = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     address,
    input  logic [XLEN-1:0]     store_data,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     load_data,
    output logic                access_fault,
    output logic [1:0]          fault_cause,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int STRB = XLEN / 8;
    localparam int OFFW = $clog2(STRB);
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, COMPLETE} state_t;

    state_t              state_q, state_d;
    logic                is_load_q, is_load_d;
    logic                sext_q, sext_d;
    logic [XLEN-1:0]     base_q, base_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic [3:0]          size_q, size_d;
    logic [XLEN-1:0]     sdata_q, sdata_d;
    logic                split_q, split_d;
    logic                gap_q, gap_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic [XLEN-1:0]     rlo_q, rlo_d;
    logic [XLEN-1:0]     load_data_q, load_data_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;

    logic [3:0]          in_size;
    logic                in_legal, in_split, accept, timeout;
    logic [2*STRB-1:0]   lane_mask;
    logic [31:0]         lo_sh, hi_sh;
    logic [XLEN-1:0]     rlo, rhi, load_ext;
    logic [2*XLEN-1:0]   wide;
    logic [OFFW-1:0]     top_byte;
    logic                sign_bit;

    always_comb begin
        case (funct3[1:0])
            2'b00:   in_size = 4'd1;
            2'b01:   in_size = 4'd2;
            2'b10:   in_size = 4'd4;
            default: in_size = 4'd8;
        endcase
        in_legal = 1'b1;
        if (funct3[1:0] == 2'b11 && (XLEN != 64 || funct3[2])) in_legal = 1'b0;
        if (funct3 == 3'b110 && XLEN != 64) in_legal = 1'b0;
        if (opcode == OP_STORE && funct3[2]) in_legal = 1'b0;
        in_split = (5'(address[OFFW-1:0]) + 5'(in_size)) > 5'(STRB);
        accept   = start && (state_q == IDLE) && (opcode == OP_LOAD || opcode == OP_STORE);
    end

    always_comb begin
        lane_mask = (((2*STRB)'(1) << size_q) - (2*STRB)'(1)) << off_q;
        lo_sh     = 32'(off_q) << 3;
        hi_sh     = (32'(STRB) - 32'(off_q)) << 3;

        busy      = (state_q != IDLE);
        done      = (state_q == COMPLETE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (state_q == BEAT_LO || state_q == BEAT_HI) begin
            mem_req = !gap_q;
            mem_we  = !is_load_q;
            if (state_q == BEAT_LO) begin
                mem_addr  = base_q;
                mem_wstrb = is_load_q ? '1 : lane_mask[STRB-1:0];
                mem_wdata = sdata_q << lo_sh;
            end else begin
                mem_addr  = base_q + XLEN'(STRB);
                mem_wstrb = is_load_q ? '1 : lane_mask[2*STRB-1:STRB];
                mem_wdata = sdata_q >> hi_sh;
            end
        end
        timeout = mem_req && !mem_ack && (wait_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Load result: the two beats form one double-width window, shifted down by the byte offset.
    always_comb begin
        rlo      = (state_q == BEAT_HI) ? rlo_q : mem_rdata;
        rhi      = (state_q == BEAT_HI) ? mem_rdata : '0;
        wide     = {rhi, rlo} >> lo_sh;
        load_ext = wide[XLEN-1:0];
        top_byte = OFFW'(size_q - 4'd1);
        sign_bit = sext_q & load_ext[{top_byte, 3'b111}];
        for (int unsigned i = 0; i < STRB; i++) begin
            if (i >= 32'(size_q)) load_ext[8*i +: 8] = {8{sign_bit}};
        end
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        sext_d      = sext_q;
        base_d      = base_q;
        off_d       = off_q;
        size_d      = size_q;
        sdata_d     = sdata_q;
        split_d     = split_q;
        gap_d       = gap_q;
        wait_d      = wait_q;
        rlo_d       = rlo_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_load_d = (opcode == OP_LOAD);
                    sext_d    = !funct3[2];
                    base_d    = {address[XLEN-1:OFFW], OFFW'(0)};
                    off_d     = address[OFFW-1:0];
                    size_d    = in_size;
                    sdata_d   = store_data;
                    split_d   = in_split;
                    gap_d     = 1'b0;
                    wait_d    = '0;
                    fault_d   = 1'b0;
                    cause_d   = 2'b00;
                    if (!in_legal) begin
                        state_d = COMPLETE;
                        fault_d = 1'b1;
                        cause_d = 2'b11;
                    end else if (in_split && MISALIGN_SPLIT == 0) begin
                        state_d = COMPLETE;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end else begin
                        state_d = BEAT_LO;
                    end
                end
            end
            BEAT_LO, BEAT_HI: begin
                // gap_q marks the idle cycle that separates the two beats on the bus.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (mem_ack) begin
                    rlo_d  = mem_rdata;
                    wait_d = '0;
                    if (state_q == BEAT_LO && split_q) begin
                        state_d = BEAT_HI;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = COMPLETE;
                        if (is_load_q) load_data_d = load_ext;
                    end
                end else if (timeout) begin
                    state_d = COMPLETE;
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            sext_q      <= 1'b0;
            base_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sdata_q     <= '0;
            split_q     <= 1'b0;
            gap_q       <= 1'b0;
            wait_q      <= '0;
            rlo_q       <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            sext_q      <= sext_d;
            base_q      <= base_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sdata_q     <= sdata_d;
            split_q     <= split_d;
            gap_q       <= gap_d;
            wait_q      <= wait_d;
            rlo_q       <= rlo_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign load_data    = load_data_q;
    assign access_fault = fault_q;
    assign fault_cause  = cause_q;
endmodule

// File: tb/tb_misaligned_load_store_unit.sv
// Bench for misaligned_load_store_unit: directed spec cases plus random ops
// checked against a byte-addressed memory model.
module tb_misaligned_load_store_unit;
    localparam int XLEN = 32;
    localparam int unsigned TO = 16;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, busy, done, access_fault, mem_req, mem_we, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  fault_cause;
    logic [3:0]  mem_wstrb;

    logic        ns_start, ns_busy, ns_done, ns_fault, ns_mem_req, ns_mem_we, ns_mem_ack;
    logic [6:0]  ns_opcode;
    logic [2:0]  ns_funct3;
    logic [31:0] ns_address, ns_store_data, ns_load_data, ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic [1:0]  ns_cause;
    logic [3:0]  ns_mem_wstrb;

    misaligned_load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
        .address(address), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .access_fault(access_fault), .fault_cause(fault_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    misaligned_load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(0), .TIMEOUT_CYCLES(16)) dut_ns (
        .clk(clk), .reset(reset), .start(ns_start), .opcode(ns_opcode), .funct3(ns_funct3),
        .address(ns_address), .store_data(ns_store_data), .busy(ns_busy), .done(ns_done),
        .load_data(ns_load_data), .access_fault(ns_fault), .fault_cause(ns_cause),
        .mem_req(ns_mem_req), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr), .mem_wstrb(ns_mem_wstrb),
        .mem_wdata(ns_mem_wdata), .mem_ack(ns_mem_ack), .mem_rdata(ns_mem_rdata)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] beat_addr [2];
    logic [3:0]  beat_strb [2];
    logic [31:0] beat_wdata [2];
    logic [31:0] ld_exp;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        logic [31:0] t;
        if (mem.exists(a)) return mem[a];
        t = a * 32'd29 + 32'd7;
        return t[7:0];
    endfunction

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference load: gather bytes one by one from memory, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned sz;
        logic [31:0] v;
        logic [7:0]  top;
        sz = size_of(f3);
        v  = '0;
        for (int unsigned i = 0; i < sz; i++) v[8*i +: 8] = rd(a + i);
        top = rd(a + sz - 1);
        if (!f3[2] && top[7]) for (int unsigned i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input bit is_load, input logic [31:0] a,
                                            input int unsigned sz, input logic [31:0] bw);
        logic [3:0]  s;
        logic [31:0] x;
        if (is_load) return 4'hF;
        s = '0;
        for (int unsigned i = 0; i < sz; i++) begin
            x = a + i - bw;
            if (x < 4) s[x[1:0]] = 1'b1;
        end
        return s;
    endfunction

    task automatic run_op(input bit is_load, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int unsigned dly, input int unsigned to_beat);
        int unsigned sz, ebeats, elat, ereq, cyc, beats, w, req_cycles;
        bit          legal, spl, prev_req;
        logic [1:0]  ecause, kk;
        logic [31:0] b0, bw, elx, mask, ew, k, got, exps;
        logic [3:0]  s;
        logic [68:0] rec;
        sz    = size_of(f3);
        legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (!is_load && f3[2]));
        spl   = ((a % 4) + sz) > 4;
        b0    = a & 32'hFFFF_FFFC;
        if (!legal) begin
            ecause = 2'b11; ebeats = 0; elat = 1; ereq = 0;
        end else if (to_beat == 1) begin
            ecause = 2'b10; ebeats = 1; elat = TO + 1; ereq = TO;
        end else if (spl && to_beat == 2) begin
            ecause = 2'b10; ebeats = 2; elat = dly + 3 + TO; ereq = dly + 1 + TO;
        end else begin
            ecause = 2'b00; ebeats = spl ? 2 : 1;
            elat = spl ? 2 * dly + 4 : dly + 2;
            ereq = ebeats * (dly + 1);
        end
        elx = ref_load(a, f3);
        rec = '0;
        bw  = '0;

        opcode = is_load ? OP_LOAD : OP_STORE;
        funct3 = f3; address = a; store_data = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opcode = 7'($urandom); funct3 = 3'($urandom); address = $urandom; store_data = $urandom;
        cyc = 1; beats = 0; prev_req = 1'b0; w = 0; req_cycles = 0;
        while (done !== 1'b1 && cyc < 80) begin
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (!prev_req) begin
                    beats++;
                    w  = 0;
                    bw = b0 + 4 * (beats - 1);
                    s  = exp_strb(is_load, a, sz, bw);
                    chk("beat_addr", mem_addr, bw);
                    chk("beat_we", mem_we, !is_load);
                    chk("beat_wstrb", mem_wstrb, s);
                    if (!is_load) begin
                        mask = '0; ew = '0;
                        for (int unsigned j = 0; j < 4; j++) begin
                            if (s[j]) begin
                                k = bw + j - a; kk = k[1:0];
                                mask[8*j +: 8] = 8'hFF;
                                ew[8*j +: 8]   = sd[8*kk +: 8];
                            end
                        end
                        chk("beat_wdata_lanes", mem_wdata & mask, ew);
                    end
                    if (beats <= 2) begin
                        beat_addr[beats-1]  = mem_addr;
                        beat_strb[beats-1]  = mem_wstrb;
                        beat_wdata[beats-1] = mem_wdata;
                    end
                    rec = {mem_we, mem_addr, mem_wstrb, mem_wdata};
                end else begin
                    chk("bus_stable", {mem_we, mem_addr, mem_wstrb, mem_wdata}, rec);
                end
                mem_ack = (w == dly) && (beats != to_beat);
                if (is_load) for (int unsigned j = 0; j < 4; j++) mem_rdata[8*j +: 8] = rd(mem_addr + j);
                else mem_rdata = $urandom;
                if (mem_ack && !is_load)
                    for (int unsigned j = 0; j < 4; j++)
                        if (mem_wstrb[j]) mem[mem_addr + j] = mem_wdata[8*j +: 8];
                w++;
            end else begin
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
            end
            prev_req = (mem_req === 1'b1);
            start    = ($urandom_range(0, 3) == 0);
            opcode   = OP_LOAD; funct3 = 3'b010; address = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done", done, 1'b1);
        chk("latency", cyc, elat);
        chk("access_fault", access_fault, ecause != 2'b00);
        chk("fault_cause", fault_cause, ecause);
        chk("beat_count", beats, ebeats);
        chk("req_cycles", req_cycles, ereq);
        chk("busy_at_done", busy, 1'b1);
        if (is_load && ecause == 2'b00) ld_exp = elx;
        chk("load_data", load_data, ld_exp);
        if (!is_load && ecause == 2'b00) begin
            got = '0; exps = '0;
            for (int unsigned i = 0; i < sz; i++) begin
                got[8*i +: 8]  = rd(a + i);
                exps[8*i +: 8] = sd[8*i +: 8];
            end
            chk("mem_after_store", got, exps);
        end
        // A start presented during the done cycle must not be taken.
        start = 1'b1; opcode = OP_STORE; funct3 = 3'b000; address = $urandom; mem_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", {busy, done}, 2'b00);
        chk("fault_held", fault_cause, ecause);
    endtask

    function automatic logic [2:0] pick_f3(input int unsigned r);
        case (r)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            4: return 3'b101;
            5: return 3'b011;
            6: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; address = '0; store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0; ld_exp = '0;
        ns_start = 1'b0; ns_opcode = '0; ns_funct3 = '0; ns_address = '0; ns_store_data = '0;
        ns_mem_ack = 1'b0; ns_mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, access_fault, fault_cause, mem_req, mem_we, mem_wstrb}, '0);
        chk("reset_data", {load_data, mem_addr}, '0);
        chk("reset_wdata", mem_wdata, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run_op(1'b1, 3'b010, 32'h100, 32'h0, 0, 0);
        chk("lw_value", load_data, 32'hDEADBEEF);
        chk("lw_addr", beat_addr[0], 32'h100);

        mem[32'h103] = 8'hAA; mem[32'h104] = 8'hBB;
        run_op(1'b1, 3'b001, 32'h103, 32'h0, 0, 0);
        chk("lh_split_value", load_data, 32'hFFFFBBAA);
        chk("lh_beats", {beat_addr[0], beat_addr[1]}, {32'h100, 32'h104});

        run_op(1'b0, 3'b010, 32'h102, 32'h11223344, 0, 0);
        chk("sw_beat1", {beat_strb[0], beat_wdata[0]}, {4'b1100, 32'h33440000});
        chk("sw_beat2", {beat_addr[1], beat_strb[1], beat_wdata[1]}, {32'h104, 4'b0011, 32'h00001122});

        run_op(1'b1, 3'b100, 32'h101, 32'h0, 0, 1);
        run_op(1'b0, 3'b010, 32'h10A, 32'hCAFEF00D, 1, 2);
        run_op(1'b0, 3'b100, 32'h104, 32'h55, 0, 0);
        run_op(1'b1, 3'b011, 32'h100, 32'h0, 0, 0);
        run_op(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h0, 1, 0);
        run_op(1'b0, 3'b001, 32'h1FF, 32'h0000A5C3, 2, 0);

        opcode = 7'b0110011; funct3 = 3'b010; address = 32'h100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad_opcode_ignored", busy, 1'b0);

        ns_opcode = OP_STORE; ns_funct3 = 3'b010; ns_address = 32'h102;
        ns_store_data = 32'h11223344; ns_start = 1'b1;
        @(posedge clk); #1;
        ns_start = 1'b0;
        chk("ns_done", ns_done, 1'b1);
        chk("ns_fault", {ns_fault, ns_cause}, 3'b101);
        chk("ns_no_req", ns_mem_req, 1'b0);
        @(posedge clk); #1;
        chk("ns_idle", {ns_busy, ns_done, ns_mem_req}, 3'b000);

        for (int n = 0; n < 40; n++) begin
            bit          il;
            logic [2:0]  f3;
            logic [31:0] ad;
            int unsigned dl, tb;
            il = 1'($urandom);
            f3 = pick_f3($urandom_range(0, 7));
            ad = 32'h300 + $urandom_range(0, 63);
            dl = $urandom_range(0, 3);
            tb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            run_op(il, f3, ad, $urandom, dl, tb);
        end

        mem_ack = 1'b0; opcode = OP_LOAD; funct3 = 3'b010; address = 32'h206; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_lo_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rst_gap", mem_req, 1'b0);
        @(posedge clk); #1;
        chk("rst_hi_req", {mem_req, busy}, 2'b11);
        reset = 1'b1;
        #1;
        ld_exp = '0;
        chk("rst_drop", {mem_req, busy, done}, 3'b000);
        chk("rst_load_data", load_data, ld_exp);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_after_reset", {busy, done}, 2'b00);
        end
        run_op(1'b1, 3'b000, 32'h200, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
